// File: rtl/noise_pkg.sv
// Shared definitions for the 24-bit LFSR noise path: width, seed, tap equation
// and the checker state encoding.
package noise_pkg;
  localparam int LFSR_W = 24;
  localparam logic [LFSR_W-1:0] SEED = 24'h8964CE;

  typedef enum logic [1:0] {IDLE, SEEK, LOCKED} chk_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[22:0], s[23] ^ s[3] ^ s[2] ^ s[0]};
  endfunction
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins first, then the
// increment of the same cycle is applied on top of it.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                 cnt <= '0;
    else if (clr)                cnt <= inc ? ONE : '0;
    else if (inc && cnt != '1)   cnt <= cnt + ONE;
  end
endmodule

// File: rtl/noise_chk.sv
// Receive-side checker for the LFSR noise stream: acquires lock, flywheels
// through corrupted samples and counts locked mispredictions.
// Optional NOISE_CHK_SEED_EN: reset straight into LOCKED with prev = SEED.
module noise_chk
  import noise_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic [LFSR_W-1:0] noise_i,
  input  logic              clear_i,
  output logic              locked_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  err_count_o
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_COUNT - 1);
`ifdef NOISE_CHK_SEED_EN
  localparam chk_state_e        RST_STATE = LOCKED;
  localparam logic [LFSR_W-1:0] RST_PREV  = SEED;
`else
  localparam chk_state_e        RST_STATE = IDLE;
  localparam logic [LFSR_W-1:0] RST_PREV  = '0;
`endif

  chk_state_e        state_q, state_d;
  logic [LFSR_W-1:0] prev_q, prev_d, exp_s;
  logic [MW-1:0]     match_q, match_d;
  logic [LW-1:0]     miss_q, miss_d;
  logic              err_q, err_d, cnt_inc, hit, nz;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RST_STATE;
      prev_q  <= RST_PREV;
      match_q <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
    end
  end

  assign exp_s = lfsr_next(prev_q);
  assign hit   = (noise_i == exp_s);
  assign nz    = (noise_i != '0);

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    cnt_inc = 1'b0;
    if (valid_i) begin
      case (state_q)
        IDLE: begin
          // all-zero is the LFSR lock-up value and can never seed a prediction
          if (nz) begin
            prev_d  = noise_i;
            match_d = '0;
            state_d = SEEK;
          end
        end
        SEEK: begin
          prev_d = noise_i;
          if (!nz) begin
            match_d = '0;
            state_d = IDLE;
          end else if (hit) begin
            if (match_q == LOCK_LAST) begin
              match_d = '0;
              miss_d  = '0;
              state_d = LOCKED;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          if (hit) begin
            miss_d = '0;
            prev_d = noise_i;
          end else begin
            err_d   = 1'b1;
            cnt_inc = 1'b1;
            if (miss_q == LOSS_LAST) begin
              miss_d  = '0;
              match_d = '0;
              prev_d  = noise_i;
              state_d = SEEK;
            end else begin
              // flywheel: keep predicting from the expected value, not the bad sample
              miss_d = miss_q + 1'b1;
              prev_d = exp_s;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc    (cnt_inc),
    .clr    (clear_i),
    .cnt    (err_count_o)
  );

  assign locked_o = (state_q == LOCKED);
  assign err_o    = err_q;
endmodule
